// File: rtl/status_led_seq_pkg.sv
// status_led_seq shared types.
// State encoding for the status LED sequencer.
package status_led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

endpackage

// File: rtl/status_led_seq_if.sv
// Status in / LED drive out bundle between the test fixture,
// the sequencer and the board top.
interface status_led_seq_if;
    logic       i_running;
    logic       i_passed;
    logic       o_led_r;
    logic       o_led_g;
    logic       o_led_b;
    logic [1:0] o_state;

    modport master (
        output i_running,
        output i_passed,
        input  o_led_r,
        input  o_led_g,
        input  o_led_b,
        input  o_state
    );

    modport slave (
        input  i_running,
        input  i_passed,
        output o_led_r,
        output o_led_g,
        output o_led_b,
        output o_state
    );
endinterface

// File: rtl/status_led_seq_timebase.sv
// Pattern timebase: tick prescaler, pattern phase and free-running
// PWM counter. i_restart realigns a new pattern to phase 0.
module led_timebase #(
    parameter int TICK_DIV = 93_750,
    parameter int PWM_BITS = 7
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_restart,
    output logic [PWM_BITS:0]   o_phase,
    output logic [PWM_BITS-1:0] o_pwm_cnt
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] presc;
    logic             tick;

    assign tick = (presc == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc     <= '0;
            o_phase   <= '0;
            o_pwm_cnt <= '0;
        end else begin
            o_pwm_cnt <= o_pwm_cnt + 1'b1;
            if (i_restart) begin
                presc   <= '0;
                o_phase <= '0;
            end else if (tick) begin
                presc   <= '0;
                o_phase <= o_phase + 1'b1;
            end else begin
                presc   <= presc + 1'b1;
            end
        end
    end
endmodule

// File: rtl/status_led_seq.sv
// Status LED sequencer: turns the fixture's running/passed pair into
// idle glow, run blink, breathing pass and fast-blink fail on the RGB LED.
module status_led_seq
    import status_led_seq_pkg::*;
#(
    parameter int TICK_DIV  = 93_750,
    parameter int PWM_BITS  = 7,
    parameter int IDLE_DUTY = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    status_led_seq_if.slave   bus
);
    logic                r_run;
    logic                r_run_q;
    logic                r_pass;
    logic                rise;
    logic                fall;
    state_e              state;
    state_e              state_d;
    logic                restart;
    logic [PWM_BITS:0]   phase;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] tri_v;
    logic                led_r, led_g, led_b;
    logic                nxt_r, nxt_g, nxt_b;

    assign rise    = r_run & ~r_run_q;
    assign fall    = ~r_run & r_run_q;
    assign restart = (state_d != state);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run   <= 1'b0;
            r_run_q <= 1'b0;
            r_pass  <= 1'b0;
            state   <= ST_IDLE;
            led_r   <= 1'b0;
            led_g   <= 1'b0;
            led_b   <= 1'b0;
        end else begin
            r_run   <= bus.i_running;
            r_run_q <= r_run;
            r_pass  <= bus.i_passed;
            state   <= state_d;
            led_r   <= nxt_r;
            led_g   <= nxt_g;
            led_b   <= nxt_b;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: if (rise) state_d = ST_RUN;
            ST_RUN:  if (fall) state_d = r_pass ? ST_PASS : ST_FAIL;
            ST_PASS: if (rise) state_d = ST_RUN;
            ST_FAIL: if (rise) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Fold the phase into a rising-then-falling breathing ramp.
    assign tri_v = phase[PWM_BITS] ? ~phase[PWM_BITS-1:0]
                                   : phase[PWM_BITS-1:0];

    always_comb begin
        nxt_r = 1'b0;
        nxt_g = 1'b0;
        nxt_b = 1'b0;
        unique case (state)
            ST_IDLE: nxt_b = (pwm_cnt < PWM_BITS'(IDLE_DUTY));
            ST_RUN:  nxt_b = ~phase[PWM_BITS];
            ST_PASS: nxt_g = (pwm_cnt < tri_v);
            ST_FAIL: nxt_r = ~phase[PWM_BITS-2];
            default: ;
        endcase
    end

    led_timebase #(
        .TICK_DIV (TICK_DIV),
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_restart (restart),
        .o_phase   (phase),
        .o_pwm_cnt (pwm_cnt)
    );

    assign bus.o_state = state;
    assign bus.o_led_r = led_r;
    assign bus.o_led_g = led_g;
    assign bus.o_led_b = led_b;
endmodule
